mvm_weight_loader: RTL and testbench
====================================

Name: mvm_weight_loader

Overview:
- Sequencer that streams weight words from a source FIFO into the MVM register files over the NoC AXI-Stream slave port.
- Tags every word with its RF address and a one-hot RF select. Walks RFs 0..N-1 and addresses 0..W-1 in order, then signals done.
- Sits in front of mvm_top's AXIS_S interface and replaces hand-built weight-write flits.

Parameters:
- TDATAW, 107, AXIS flit data width
- DESTW, 12, AXIS destination width
- DATAW, 32, weight word width
- ADDRW, 9, RF address width
- NUM_RF, 64, number of RFs (one-hot select bits)
- RF_SEL_LSB, 41, flit bit position of RF 0 select; requires RF_SEL_LSB+NUM_RF <= TDATAW

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- START  in  1  single-cycle load request
- CFG_NUM_RF  in  $clog2(NUM_RF)+1  number of RFs to load
- CFG_WORDS  in  ADDRW+1  words per RF
- CFG_DEST  in  DESTW  NoC destination of the MVM node
- BUSY  out  1  load in progress
- DONE  out  1  one-cycle pulse after the last flit is accepted
- W_TVALID  in  1  weight source valid
- W_TDATA  in  DATAW  weight word
- W_TREADY  out  1  weight source ready
- AXIS_M_TVALID  out  1  flit valid
- AXIS_M_TDATA  out  TDATAW  flit data
- AXIS_M_TDEST  out  DESTW  flit destination
- AXIS_M_TLAST  out  1  always 1 when valid (single-flit packets)
- AXIS_M_TREADY  in  1  NoC ready
- STALL_CNT  out  32  backpressure cycle count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state IDLE; BUSY, DONE, W_TREADY, AXIS_M_TVALID, AXIS_M_TLAST = 0; AXIS_M_TDATA, AXIS_M_TDEST = 0; counters = 0; STALL_CNT = 0.
- States: IDLE, LOAD, DRAIN, FIN.
- IDLE:
  - START=1 latches CFG_* and clears rf_cnt and addr_cnt.
  - If CFG_NUM_RF==0 or CFG_WORDS==0, go to FIN. Otherwise go to LOAD.
  - START is ignored in every state except IDLE.
- LOAD:
  - W_TREADY = !AXIS_M_TVALID || AXIS_M_TREADY (one-entry output register, full throughput).
  - On a W_TVALID&&W_TREADY beat, the output register loads on the next edge:
    - tdata[DATAW-1:0] = W_TDATA
    - tdata[DATAW+ADDRW-1:DATAW] = addr_cnt
    - tdata[RF_SEL_LSB+rf_cnt] = 1; all other bits 0
    - tdest = latched dest; tlast = 1; tvalid = 1
  - Latency: 1 cycle from input accept to AXIS_M_TVALID.
  - Counter advance per accepted word: addr_cnt increments. When addr_cnt == words-1, addr_cnt wraps to 0 and rf_cnt increments.
  - On the final word (rf_cnt == num_rf-1 and addr_cnt == words-1), go to DRAIN.
  - Output hold: AXIS_M_TVALID clears when the flit is accepted and no new word is accepted in the same cycle.
- AXIS rules:
  - While AXIS_M_TVALID=1 and AXIS_M_TREADY=0, TDATA, TDEST and TLAST hold stable.
  - Simultaneous downstream accept and upstream accept: the new flit replaces the old one with no bubble.
- DRAIN:
  - W_TREADY = 0.
  - Wait until the last flit is accepted (AXIS_M_TVALID && AXIS_M_TREADY), then go to FIN.
- FIN: DONE=1 for exactly one cycle, then go to IDLE.
- BUSY = 1 in LOAD, DRAIN and FIN.
- Out-of-range configuration: CFG_NUM_RF > NUM_RF is clamped to NUM_RF. CFG_WORDS > 2^ADDRW is clamped to 2^ADDRW.
- Reset mid-operation: any in-flight flit is dropped (TVALID -> 0 next cycle), no DONE is generated, and the block returns to IDLE.

Optional Feature:
- Macro: MVM_LOADER_PERF_EN.
- Defined:
  - STALL_CNT increments every cycle AXIS_M_TVALID && !AXIS_M_TREADY.
  - It saturates at 2^32-1 and clears on the START accept and on RST.
- Undefined: STALL_CNT tied to 0 and no counter logic is generated.

Test Plan:
- Basic load: START, NUM_RF=2, WORDS=3, dest=0x002, words 0xA0..0xA5, TREADY=1.
  - Expect 6 flits with addr 0,1,2,0,1,2.
  - Select bit 41 set on flits 1-3 and bit 42 on flits 4-6; tdata[31:0] = words in order.
  - TDEST=0x002, TLAST=1 on every flit; DONE one cycle after the 6th accept.
- Backpressure: same config, TREADY low for 4 cycles at flit 2.
  - Flit 2 holds stable and W_TREADY=0 while the output register is full.
  - No loss or duplication; STALL_CNT=4 with the macro defined, 0 without.
- Full RF walk: NUM_RF=64, WORDS=1.
  - Select bit walks from 41 to 104, one-hot on every flit; DONE after 64 flits.
- Zero config: START with WORDS=0.
  - No flits and W_TREADY stays 0; BUSY high for 1 cycle then DONE pulse.
- Reset mid-load: RST asserted after 3 of 6 words.
  - Next cycle TVALID=0 and BUSY=0, no DONE.
  - A following START reloads from RF 0, addr 0.
- START while busy: second START pulse during LOAD has no effect on counters or the flit sequence.

Source files
------------

// File: rtl/mvm_weight_loader.sv
// ---------------------------------------------------------------------------
// mvm_weight_loader
//
// Streams weight words from a source FIFO into the MVM register files through
// the NoC AXI-Stream slave port of mvm_top. Each word becomes one single-flit
// packet that carries the weight, its RF address and a one-hot RF select.
// The walk goes RF 0..num_rf-1 and, within each RF, address 0..words-1.
// DONE pulses once the last flit has been accepted by the NoC.
//
// Optional feature macro: MVM_LOADER_PERF_EN
//   defined   : STALL_CNT counts cycles with AXIS_M_TVALID && !AXIS_M_TREADY
//               (saturating, cleared by RST and by an accepted START)
//   undefined : STALL_CNT is tied to zero and no counter is built
//
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   START              single-cycle load request (honoured only when idle)
//   CFG_NUM_RF         number of RFs to load (clamped to NUM_RF)
//   CFG_WORDS          words per RF (clamped to 2^ADDRW)
//   CFG_DEST           NoC destination of the MVM node
//   BUSY               load in progress (LOAD, DRAIN, FIN)
//   DONE               one-cycle pulse after the last flit is accepted
//   W_TVALID/W_TDATA/W_TREADY               weight word source
//   AXIS_M_TVALID/TDATA/TDEST/TLAST/TREADY  flit output toward the NoC
//   STALL_CNT          output backpressure cycle count (see macro)
// ---------------------------------------------------------------------------
module mvm_weight_loader #(
   parameter int TDATAW     = 107,
   parameter int DESTW      = 12,
   parameter int DATAW      = 32,
   parameter int ADDRW      = 9,
   parameter int NUM_RF     = 64,
   parameter int RF_SEL_LSB = 41   // RF_SEL_LSB + NUM_RF must not exceed TDATAW
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      START,
   input  logic [$clog2(NUM_RF):0]   CFG_NUM_RF,
   input  logic [ADDRW:0]            CFG_WORDS,
   input  logic [DESTW-1:0]          CFG_DEST,
   output logic                      BUSY,
   output logic                      DONE,
   input  logic                      W_TVALID,
   input  logic [DATAW-1:0]          W_TDATA,
   output logic                      W_TREADY,
   output logic                      AXIS_M_TVALID,
   output logic [TDATAW-1:0]         AXIS_M_TDATA,
   output logic [DESTW-1:0]          AXIS_M_TDEST,
   output logic                      AXIS_M_TLAST,
   input  logic                      AXIS_M_TREADY,
   output logic [31:0]               STALL_CNT
);

   localparam int RFW = $clog2(NUM_RF) + 1;

   localparam logic [RFW-1:0] LP_NUM_RF    = RFW'(NUM_RF);
   localparam logic [RFW-1:0] LP_RF_ONE    = RFW'(1);
   localparam logic [ADDRW:0] LP_MAX_WORDS = {1'b1, {ADDRW{1'b0}}};
   localparam logic [ADDRW:0] LP_WORD_ONE  = (ADDRW+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t r_state;
   state_t w_next;

   // latched configuration
   logic [RFW-1:0]    r_num_rf;
   logic [ADDRW:0]    r_words;
   logic [DESTW-1:0]  r_dest;

   // walk position of the next word to be accepted
   logic [RFW-1:0]    r_rf_cnt;
   logic [ADDRW-1:0]  r_addr_cnt;

   // one-entry output register
   logic              r_tvalid;
   logic [TDATAW-1:0] r_tdata;
   logic [DESTW-1:0]  r_tdest;
   logic              r_tlast;

   logic [RFW-1:0]    w_cfg_num_rf;
   logic [ADDRW:0]    w_cfg_words;
   logic              w_start_acc;
   logic              w_tready;
   logic              w_beat;
   logic              w_out_acc;
   logic              w_addr_last;
   logic              w_rf_last;
   logic              w_busy;
   logic              w_done;
   logic [NUM_RF-1:0] w_sel;
   logic [TDATAW-1:0] w_flit;

   // ------------------------------------------------------------------------
   // Configuration clamp and handshakes
   // ------------------------------------------------------------------------
   assign w_cfg_num_rf = (CFG_NUM_RF > LP_NUM_RF)   ? LP_NUM_RF    : CFG_NUM_RF;
   assign w_cfg_words  = (CFG_WORDS  > LP_MAX_WORDS) ? LP_MAX_WORDS : CFG_WORDS;

   assign w_start_acc = (r_state == S_IDLE) && START;

   // Output register can take a new word when empty or draining this cycle,
   // which gives full throughput with no bubble on simultaneous handshakes.
   assign w_tready  = (r_state == S_LOAD) && (!r_tvalid || AXIS_M_TREADY);
   assign w_beat    = W_TVALID && w_tready;
   assign w_out_acc = r_tvalid && AXIS_M_TREADY;

   // Compare count+1 against the configured size so the counters never need
   // a separate "size minus one" register.
   assign w_addr_last = (({1'b0, r_addr_cnt} + LP_WORD_ONE) == r_words);
   assign w_rf_last   = ((r_rf_cnt + LP_RF_ONE) == r_num_rf);

   // ------------------------------------------------------------------------
   // Flit assembly: weight, RF address, one-hot RF select, zeros elsewhere
   // ------------------------------------------------------------------------
   assign w_sel = {{(NUM_RF-1){1'b0}}, 1'b1} << r_rf_cnt;

   always_comb begin
      w_flit                               = '0;
      w_flit[DATAW-1:0]                    = W_TDATA;
      w_flit[DATAW+ADDRW-1:DATAW]          = r_addr_cnt;
      w_flit[RF_SEL_LSB +: NUM_RF]         = w_sel;
   end

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and status outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               if ((w_cfg_num_rf == '0) || (w_cfg_words == '0)) begin
                  w_next = S_FIN;
               end else begin
                  w_next = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            w_busy = 1'b1;
            if (w_beat && w_addr_last && w_rf_last) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (w_out_acc) begin
               w_next = S_FIN;
            end
         end
         S_FIN: begin
            w_busy = 1'b1;
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Configuration latch, walk counters and output register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_num_rf   <= '0;
         r_words    <= '0;
         r_dest     <= '0;
         r_rf_cnt   <= '0;
         r_addr_cnt <= '0;
         r_tvalid   <= 1'b0;
         r_tdata    <= '0;
         r_tdest    <= '0;
         r_tlast    <= 1'b0;
      end else begin
         if (w_start_acc) begin
            r_num_rf   <= w_cfg_num_rf;
            r_words    <= w_cfg_words;
            r_dest     <= CFG_DEST;
            r_rf_cnt   <= '0;
            r_addr_cnt <= '0;
         end

         if (w_beat) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_flit;
            r_tdest  <= r_dest;
            r_tlast  <= 1'b1;
            if (w_addr_last) begin
               r_addr_cnt <= '0;
               r_rf_cnt   <= r_rf_cnt + LP_RF_ONE;
            end else begin
               r_addr_cnt <= r_addr_cnt + ADDRW'(1);
            end
         end else if (w_out_acc) begin
            r_tvalid <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Backpressure counter
   // ------------------------------------------------------------------------
`ifdef MVM_LOADER_PERF_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_stall_cnt <= '0;
      end else if (w_start_acc) begin
         r_stall_cnt <= '0;
      end else if (r_tvalid && !AXIS_M_TREADY && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign STALL_CNT = r_stall_cnt;
`else
   assign STALL_CNT = '0;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign BUSY          = w_busy;
   assign DONE          = w_done;
   assign W_TREADY      = w_tready;
   assign AXIS_M_TVALID = r_tvalid;
   assign AXIS_M_TDATA  = r_tdata;
   assign AXIS_M_TDEST  = r_tdest;
   assign AXIS_M_TLAST  = r_tlast;

endmodule

// File: tb/tb_mvm_weight_loader.sv
// ---------------------------------------------------------------------------
// tb_mvm_weight_loader
//
// Randomized self-checking bench for mvm_weight_loader. A reference model
// derives each expected flit from the index of the accepted word (rf = i /
// words, addr = i % words) and keeps a queue of flits in flight. Inputs are
// driven on the falling edge, outputs are checked shortly after it.
// ---------------------------------------------------------------------------
module tb_mvm_weight_loader;

   logic         CLK = 1'b0;
   logic         RST;
   logic         START;
   logic [6:0]   CFG_NUM_RF;
   logic [9:0]   CFG_WORDS;
   logic [11:0]  CFG_DEST;
   logic         BUSY;
   logic         DONE;
   logic         W_TVALID;
   logic [31:0]  W_TDATA;
   logic         W_TREADY;
   logic         AXIS_M_TVALID;
   logic [106:0] AXIS_M_TDATA;
   logic [11:0]  AXIS_M_TDEST;
   logic         AXIS_M_TLAST;
   logic         AXIS_M_TREADY;
   logic [31:0]  STALL_CNT;

   int n_tests = 0;
   int n_fail  = 0;
   int last_stall_exp;

   mvm_weight_loader #(
      .TDATAW     (107),
      .DESTW      (12),
      .DATAW      (32),
      .ADDRW      (9),
      .NUM_RF     (64),
      .RF_SEL_LSB (41)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .START         (START),
      .CFG_NUM_RF    (CFG_NUM_RF),
      .CFG_WORDS     (CFG_WORDS),
      .CFG_DEST      (CFG_DEST),
      .BUSY          (BUSY),
      .DONE          (DONE),
      .W_TVALID      (W_TVALID),
      .W_TDATA       (W_TDATA),
      .W_TREADY      (W_TREADY),
      .AXIS_M_TVALID (AXIS_M_TVALID),
      .AXIS_M_TDATA  (AXIS_M_TDATA),
      .AXIS_M_TDEST  (AXIS_M_TDEST),
      .AXIS_M_TLAST  (AXIS_M_TLAST),
      .AXIS_M_TREADY (AXIS_M_TREADY),
      .STALL_CNT     (STALL_CNT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected flit for the idx-th word of a load with wpr words per RF
   function automatic logic [106:0] exp_flit(input logic [31:0] w,
                                             input int idx, input int wpr);
      logic [106:0] f;
      int rf;
      int a;
      rf = idx / wpr;
      a  = idx % wpr;
      f  = '0;
      f[31:0]    = w;
      f[40:32]   = a[8:0];
      f[41 + rf] = 1'b1;
      return f;
   endfunction

   function automatic int expected_stall(input int s);
`ifdef MVM_LOADER_PERF_EN
      return s;
`else
      return (s < 0) ? s : 0;
`endif
   endfunction

   // One complete load. pv/pr: percent chance of W_TVALID / AXIS_M_TREADY.
   // bp: hold TREADY low for 4 cycles while the second flit is presented.
   // seq: weights are 0xA0 + index. sa: cycle of a stray START (0 = none).
   task automatic run_load(input int nrf, input int words,
                           input logic [11:0] dest, input int pv, input int pr,
                           input bit bp, input bit seq, input int sa);
      int           enrf, ewords, total, acc, popped, cyc, stall_exp, stall_left;
      bit           done_due, due_now, finished, prev_stall;
      logic [106:0] q[$];
      logic [106:0] prev_data, f;
      logic [11:0]  prev_dest;

      enrf   = (nrf > 64) ? 64 : nrf;
      ewords = (words > 512) ? 512 : words;
      total  = enrf * ewords;
      acc = 0; popped = 0; cyc = 0; stall_exp = 0; stall_left = 4;
      finished = 0; prev_stall = 0; prev_data = '0; prev_dest = '0;

      @(negedge CLK);
      START         = 1'b1;
      CFG_NUM_RF    = 7'(nrf);
      CFG_WORDS     = 10'(words);
      CFG_DEST      = dest;
      W_TVALID      = 1'b0;
      AXIS_M_TREADY = 1'b1;
      #1;
      check("idle_busy", BUSY, 0);
      check("idle_wtready", W_TREADY, 0);
      done_due = (total == 0);

      while (!finished) begin
         @(negedge CLK);
         cyc++;
         START = (sa != 0) && (cyc == sa);
         if (START) begin
            CFG_NUM_RF = 7'd1;
            CFG_WORDS  = 10'd1;
            CFG_DEST   = ~dest;
         end
         W_TVALID = ($urandom_range(0, 99) < pv);
         W_TDATA  = seq ? 32'(32'hA0 + acc) : $urandom;
         if (bp) begin
            if (popped == 1 && AXIS_M_TVALID && stall_left > 0) begin
               AXIS_M_TREADY = 1'b0;
               stall_left--;
            end else begin
               AXIS_M_TREADY = 1'b1;
            end
         end else begin
            AXIS_M_TREADY = ($urandom_range(0, 99) < pr);
         end
         #1;

         due_now  = done_due;
         done_due = 0;
         if (due_now) begin
            check("done_pulse", DONE, 1);
            check("busy_fin", BUSY, 1);
            check("stall_cnt", STALL_CNT, expected_stall(stall_exp));
            finished = 1;
         end else begin
            check("done_early", DONE, 0);
            check("busy_run", BUSY, 1);
         end
         check("tvalid", AXIS_M_TVALID, q.size() != 0);
         if (prev_stall) begin
            check("hold_data", AXIS_M_TDATA, prev_data);
            check("hold_dest", AXIS_M_TDEST, prev_dest);
         end
         check("w_tready", W_TREADY,
               (acc < total) && (!AXIS_M_TVALID || AXIS_M_TREADY));

         if (AXIS_M_TVALID && !AXIS_M_TREADY) stall_exp++;
         prev_stall = AXIS_M_TVALID && !AXIS_M_TREADY;
         prev_data  = AXIS_M_TDATA;
         prev_dest  = AXIS_M_TDEST;

         if (AXIS_M_TVALID && AXIS_M_TREADY) begin
            if (q.size() == 0) begin
               check("spurious_flit", 1, 0);
            end else begin
               f = q.pop_front();
               check("flit_data", AXIS_M_TDATA, f);
               check("flit_dest", AXIS_M_TDEST, dest);
               check("flit_last", AXIS_M_TLAST, 1);
               popped++;
               if (popped == total) done_due = 1;
            end
         end
         if (W_TVALID && W_TREADY) begin
            if (acc < total) q.push_back(exp_flit(W_TDATA, acc, ewords));
            acc++;
         end

         if (!finished && cyc > total * 20 + 40) begin
            check("timeout", 1, 0);
            finished = 1;
         end
      end

      @(negedge CLK);
      START    = 1'b0;
      W_TVALID = 1'b0;
      #1;
      check("post_busy", BUSY, 0);
      check("post_done", DONE, 0);
      check("post_tvalid", AXIS_M_TVALID, 0);
      last_stall_exp = stall_exp;
   endtask

   task automatic reset_mid_load();
      int n;
      int cyc;
      @(negedge CLK);
      START         = 1'b1;
      CFG_NUM_RF    = 7'd2;
      CFG_WORDS     = 10'd3;
      CFG_DEST      = 12'h005;
      W_TVALID      = 1'b0;
      AXIS_M_TREADY = 1'b1;
      n = 0;
      cyc = 0;
      while (n < 3 && cyc < 50) begin
         @(negedge CLK);
         START    = 1'b0;
         W_TVALID = 1'b1;
         W_TDATA  = $urandom;
         cyc++;
         #1;
         if (W_TVALID && W_TREADY) n++;
      end
      check("rst_words_taken", n, 3);
      @(negedge CLK);
      W_TVALID = 1'b0;
      RST      = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("rst_tvalid", AXIS_M_TVALID, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_stall", STALL_CNT, 0);
      repeat (3) begin
         @(negedge CLK);
         #1;
         check("rst_no_done", DONE, 0);
         check("rst_idle", BUSY, 0);
         check("rst_wtready", W_TREADY, 0);
      end
   endtask

   initial begin
      RST = 1'b1;
      START = 1'b0;
      CFG_NUM_RF = '0;
      CFG_WORDS = '0;
      CFG_DEST = '0;
      W_TVALID = 1'b0;
      W_TDATA = '0;
      AXIS_M_TREADY = 1'b0;
      last_stall_exp = 0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      #1;
      check("rst_tvalid0", AXIS_M_TVALID, 0);
      check("rst_busy0", BUSY, 0);
      check("rst_done0", DONE, 0);
      check("rst_wtready0", W_TREADY, 0);
      check("rst_tdata0", AXIS_M_TDATA, 0);
      check("rst_tdest0", AXIS_M_TDEST, 0);
      check("rst_tlast0", AXIS_M_TLAST, 0);
      check("rst_stall0", STALL_CNT, 0);

      // basic load
      run_load(2, 3, 12'h002, 100, 100, 1'b0, 1'b1, 0);
      // backpressure on the second flit
      run_load(2, 3, 12'h002, 100, 100, 1'b1, 1'b1, 0);
      check("bp_stall4", STALL_CNT, expected_stall(4));
      // full RF walk and clamped RF count
      run_load(64, 1, 12'h0AB, 100, 100, 1'b0, 0, 0);
      run_load(100, 1, 12'h3C1, 80, 70, 1'b0, 0, 0);
      // zero configurations
      run_load(2, 0, 12'h011, 100, 100, 1'b0, 0, 0);
      run_load(0, 3, 12'h012, 100, 100, 1'b0, 0, 0);
      // reset mid-load, then a clean reload
      reset_mid_load();
      run_load(2, 3, 12'h002, 100, 100, 1'b0, 1'b1, 0);
      // stray START during LOAD
      run_load(2, 3, 12'h7E0, 100, 100, 1'b0, 1'b1, 3);
      run_load(3, 4, 12'h7E1, 70, 60, 1'b0, 0, 5);
      // clamped word count
      run_load(1, 600, 12'h101, 90, 90, 1'b0, 0, 0);
      // random configurations and handshake rates
      for (int i = 0; i < 10; i++) begin
         run_load($urandom_range(0, 70), $urandom_range(0, 6),
                  12'($urandom), $urandom_range(30, 100),
                  $urandom_range(30, 100), 1'b0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
